cpu_cfg_responder: RTL and testbench

CPU-side end of the N64 config command channel. It detects a command posted by the N64-side config registers (cfg_pending/cfg_cmd/args), latches it and interrupts the MCU. It exposes command and arguments on the CPU register bus and returns response data, done, error and optional N64 IRQ. A watchdog auto-completes with error if the CPU never answers.

---
 rtl/n64_cfg_pkg.sv | 41 ++++
 rtl/cfg_watchdog.sv | 30 +++
 rtl/cpu_cfg_responder.sv | 163 ++++++++++++++++
 tb/tb_cpu_cfg_responder.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/n64_cfg_pkg.sv
// Shared definitions for the N64 config command channel: register map,
// CONTROL/STATUS bit positions and the responder state encoding.
package n64_cfg_pkg;

    typedef enum logic [2:0] {
        REG_STATUS  = 3'd0,
        REG_ARG0    = 3'd1,
        REG_ARG1    = 3'd2,
        REG_DATA0   = 3'd3,
        REG_DATA1   = 3'd4,
        REG_VERSION = 3'd5,
        REG_CONTROL = 3'd6
    } reg_idx_e;

    localparam int CTRL_DONE    = 0;
    localparam int CTRL_ERROR   = 1;
    localparam int CTRL_N64_IRQ = 2;
    localparam int CTRL_CLR_IRQ = 3;

    localparam int STAT_BUSY    = 31;
    localparam int STAT_IRQ     = 30;
    localparam int STAT_TIMEOUT = 29;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    function automatic logic [31:0] status_word(input logic busy, input logic irq,
                                                input logic timeout, input logic [7:0] cmd);
        logic [31:0] w;
        w               = '0;
        w[STAT_BUSY]    = busy;
        w[STAT_IRQ]     = irq;
        w[STAT_TIMEOUT] = timeout;
        w[7:0]          = cmd;
        return w;
    endfunction

endpackage

// File: rtl/cfg_watchdog.sv
// Saturating cycle counter that flags the last allowed BUSY cycle.
// TIMEOUT_CYCLES of 0 disables expiry entirely.
module cfg_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned LAST_INT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [W-1:0] SAT  = W'(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(LAST_INT);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (enable && count_reg != SAT) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expire = (TIMEOUT_CYCLES != 0) && enable && (count_reg == LAST);

endmodule

// File: rtl/cpu_cfg_responder.sv
// CPU-side responder for N64 config commands: captures a posted command,
// interrupts the MCU, and returns its response or a watchdog error.
module cpu_cfg_responder
    import n64_cfg_pkg::*;
#(
    parameter logic [31:0] VERSION        = 32'h5343_7632,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_req,
    input  logic        bus_write,
    input  logic [2:0]  bus_address,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ack,
    output logic        cpu_irq,
    input  logic        n64_reset,
    input  logic        cfg_pending,
    input  logic [7:0]  cfg_cmd,
    input  logic [31:0] cfg_rdata0,
    input  logic [31:0] cfg_rdata1,
    output logic        cfg_done,
    output logic        cfg_error,
    output logic        cfg_irq,
    output logic [31:0] cfg_wdata0,
    output logic [31:0] cfg_wdata1,
    output logic [31:0] cfg_version
);

    state_e      state_reg;
    logic        cpu_irq_reg;
    logic        timeout_reg;
    logic        done_reg;
    logic        error_reg;
    logic        n64_irq_reg;
    logic        ack_reg;
    logic [31:0] rdata_reg;
    logic [7:0]  cmd_reg;
    logic [31:0] arg0_reg;
    logic [31:0] arg1_reg;
    logic [31:0] data0_reg;
    logic [31:0] data1_reg;

    logic        capture;
    logic        ctrl_write;
    logic        done_write;
    logic        expire;
    logic [31:0] read_data;

    assign capture    = (state_reg == ST_IDLE) && cfg_pending;
    assign ctrl_write = bus_req && bus_write && (bus_address == REG_CONTROL);
    assign done_write = ctrl_write && bus_wdata[CTRL_DONE] && (state_reg == ST_BUSY);

    cfg_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset || n64_reset),
        .clear  (capture),
        .enable (state_reg == ST_BUSY),
        .expire (expire)
    );

    always_comb begin
        read_data = '0;
        case (bus_address)
            REG_STATUS:  read_data = status_word(state_reg == ST_BUSY, cpu_irq_reg,
                                                 timeout_reg, cmd_reg);
            REG_ARG0:    read_data = arg0_reg;
            REG_ARG1:    read_data = arg1_reg;
            REG_DATA0:   read_data = data0_reg;
            REG_DATA1:   read_data = data1_reg;
            REG_VERSION: read_data = VERSION;
            default:     read_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            cpu_irq_reg <= 1'b0;
            timeout_reg <= 1'b0;
            done_reg    <= 1'b0;
            error_reg   <= 1'b0;
            n64_irq_reg <= 1'b0;
            ack_reg     <= 1'b0;
            rdata_reg   <= '0;
            cmd_reg     <= '0;
            arg0_reg    <= '0;
            arg1_reg    <= '0;
            data0_reg   <= '0;
            data1_reg   <= '0;
        end else if (n64_reset) begin
            // Console reset aborts the channel but keeps the CPU's response data.
            state_reg   <= ST_IDLE;
            cpu_irq_reg <= 1'b0;
            timeout_reg <= 1'b0;
            done_reg    <= 1'b0;
            error_reg   <= 1'b0;
            n64_irq_reg <= 1'b0;
            ack_reg     <= 1'b0;
        end else begin
            done_reg    <= 1'b0;
            n64_irq_reg <= 1'b0;
            ack_reg     <= bus_req;

            if (bus_req) begin
                if (bus_write) begin
                    rdata_reg <= '0;
                    if (bus_address == REG_DATA0) data0_reg <= bus_wdata;
                    if (bus_address == REG_DATA1) data1_reg <= bus_wdata;
                end else begin
                    rdata_reg <= read_data;
                end
            end

            if (ctrl_write && bus_wdata[CTRL_N64_IRQ]) n64_irq_reg <= 1'b1;
            if (ctrl_write && bus_wdata[CTRL_CLR_IRQ]) cpu_irq_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    // Capture is assigned after the clear above so it wins a same-cycle race.
                    if (cfg_pending) begin
                        cmd_reg     <= cfg_cmd;
                        arg0_reg    <= cfg_rdata0;
                        arg1_reg    <= cfg_rdata1;
                        cpu_irq_reg <= 1'b1;
                        timeout_reg <= 1'b0;
                        state_reg   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (done_write) begin
                        done_reg  <= 1'b1;
                        error_reg <= bus_wdata[CTRL_ERROR];
                        state_reg <= ST_HOLD;
                    end else if (expire) begin
                        done_reg    <= 1'b1;
                        error_reg   <= 1'b1;
                        timeout_reg <= 1'b1;
                        cpu_irq_reg <= 1'b0;
                        state_reg   <= ST_HOLD;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_rdata   = rdata_reg;
    assign bus_ack     = ack_reg;
    assign cpu_irq     = cpu_irq_reg;
    assign cfg_done    = done_reg;
    assign cfg_error   = error_reg;
    assign cfg_irq     = n64_irq_reg;
    assign cfg_wdata0  = data0_reg;
    assign cfg_wdata1  = data1_reg;
    assign cfg_version = VERSION;

endmodule

// File: tb/tb_cpu_cfg_responder.sv
// Randomized self-checking bench for cpu_cfg_responder against a register-level model.
module tb_cpu_cfg_responder;

    localparam int TO = 16;
    localparam logic [31:0] VER = 32'h5343_7632;

    logic        clk = 1'b0;
    logic        reset, bus_req, bus_write, n64_reset, cfg_pending;
    logic [2:0]  bus_address;
    logic [31:0] bus_wdata, bus_rdata, cfg_rdata0, cfg_rdata1;
    logic [31:0] cfg_wdata0, cfg_wdata1, cfg_version;
    logic [7:0]  cfg_cmd;
    logic        bus_ack, cpu_irq, cfg_done, cfg_error, cfg_irq;

    always #5 clk = ~clk;

    cpu_cfg_responder #(.VERSION(VER), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .bus_req(bus_req), .bus_write(bus_write),
        .bus_address(bus_address), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack), .cpu_irq(cpu_irq), .n64_reset(n64_reset),
        .cfg_pending(cfg_pending), .cfg_cmd(cfg_cmd), .cfg_rdata0(cfg_rdata0),
        .cfg_rdata1(cfg_rdata1), .cfg_done(cfg_done), .cfg_error(cfg_error),
        .cfg_irq(cfg_irq), .cfg_wdata0(cfg_wdata0), .cfg_wdata1(cfg_wdata1),
        .cfg_version(cfg_version)
    );

    int vecs = 0;
    int errs = 0;
    int done_cnt = 0;
    int irq_cnt = 0;

    always @(negedge clk) begin
        if (cfg_done === 1'b1) done_cnt++;
        if (cfg_irq === 1'b1) irq_cnt++;
    end

    // Reference model: the CPU-visible register contents.
    logic        m_busy, m_irq, m_tflag;
    logic [7:0]  m_cmd;
    logic [31:0] m_arg0, m_arg1, m_d0, m_d1;

    function automatic logic [31:0] m_status();
        return {m_busy, m_irq, m_tflag, 21'd0, m_cmd};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d, output logic ack);
        bus_req = 1'b1; bus_write = 1'b0; bus_address = a;
        tick();
        bus_req = 1'b0;
        d = bus_rdata;
        ack = bus_ack;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] w);
        bus_req = 1'b1; bus_write = 1'b1; bus_address = a; bus_wdata = w;
        tick();
        bus_req = 1'b0; bus_write = 1'b0;
    endtask

    task automatic post_cmd(input logic [7:0] c, input logic [31:0] a0, input logic [31:0] a1);
        cfg_cmd = c; cfg_rdata0 = a0; cfg_rdata1 = a1; cfg_pending = 1'b1;
        tick();
        cfg_pending = 1'b0;
        m_busy = 1'b1; m_irq = 1'b1; m_tflag = 1'b0;
        m_cmd = c; m_arg0 = a0; m_arg1 = a1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic ack;
        reset = 1'b1; n64_reset = 1'b0; bus_req = 1'b0; bus_write = 1'b0;
        bus_address = '0; bus_wdata = '0; cfg_pending = 1'b0; cfg_cmd = '0;
        cfg_rdata0 = '0; cfg_rdata1 = '0;
        repeat (3) tick();
        vecs++;
        if ({cpu_irq, cfg_done, cfg_error, cfg_irq, bus_ack} !== 5'b0) begin
            errs++;
            $display("FAIL reset_flags got %b want 00000", {cpu_irq, cfg_done, cfg_error, cfg_irq, bus_ack});
        end
        vecs++;
        if ({bus_rdata, cfg_wdata0, cfg_wdata1} !== 96'd0) begin
            errs++;
            $display("FAIL reset_data got %h %h %h want zeros", bus_rdata, cfg_wdata0, cfg_wdata1);
        end
        reset = 1'b0;
        m_busy = 0; m_irq = 0; m_tflag = 0; m_cmd = '0;
        m_arg0 = '0; m_arg1 = '0; m_d0 = '0; m_d1 = '0;
        tick();
        bus_rd(3'd0, d, ack);
        vecs++;
        if (d !== m_status() || ack !== 1'b1) begin
            errs++;
            $display("FAIL reset_status got %h ack %b want %h ack 1", d, ack, m_status());
        end
        bus_rd(3'd5, d, ack);
        vecs++;
        if (d !== VER || cfg_version !== VER) begin
            errs++;
            $display("FAIL version got %h/%h want %h", d, cfg_version, VER);
        end
    endtask

    task automatic test_basic();
        logic [31:0] d, w0, w1;
        logic [7:0] c;
        logic ack, err;
        int c0;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                c = 8'h12; w0 = 32'hCAFE_0001; err = 1'b0;
                post_cmd(c, 32'hDEAD_BEEF, 32'h0000_0010);
            end else begin
                c = 8'($urandom); w0 = $urandom; err = 1'($urandom_range(0, 1));
                post_cmd(c, $urandom, $urandom);
            end
            w1 = $urandom;
            vecs++;
            if (cpu_irq !== 1'b1) begin
                errs++;
                $display("FAIL capture_irq got %b want 1", cpu_irq);
            end
            bus_rd(3'd0, d, ack);
            vecs++;
            if (d !== m_status() || ack !== 1'b1) begin
                errs++;
                $display("FAIL busy_status got %h ack %b want %h ack 1", d, ack, m_status());
            end
            bus_rd(3'd1, d, ack);
            vecs++;
            if (d !== m_arg0) begin
                errs++;
                $display("FAIL arg0 got %h want %h", d, m_arg0);
            end
            bus_rd(3'd2, d, ack);
            vecs++;
            if (d !== m_arg1) begin
                errs++;
                $display("FAIL arg1 got %h want %h", d, m_arg1);
            end
            bus_wr(3'd3, w0); m_d0 = w0;
            bus_wr(3'd4, w1); m_d1 = w1;
            vecs++;
            if (cfg_wdata0 !== m_d0 || cfg_wdata1 !== m_d1) begin
                errs++;
                $display("FAIL wdata got %h %h want %h %h", cfg_wdata0, cfg_wdata1, m_d0, m_d1);
            end
            bus_rd(3'd4, d, ack);
            vecs++;
            if (d !== m_d1) begin
                errs++;
                $display("FAIL data1_read got %h want %h", d, m_d1);
            end
            if (i != 0 && $urandom_range(0, 1) == 1) begin
                bus_wr(3'd6, 32'h8);
                m_irq = 1'b0;
                vecs++;
                if (cpu_irq !== 1'b0) begin
                    errs++;
                    $display("FAIL clear_irq got %b want 0", cpu_irq);
                end
            end
            c0 = done_cnt;
            bus_wr(3'd6, {30'd0, err, 1'b1});
            m_busy = 1'b0;
            vecs++;
            if (cfg_done !== 1'b1 || cfg_error !== err) begin
                errs++;
                $display("FAIL done_pulse got done %b err %b want 1 %b", cfg_done, cfg_error, err);
            end
            tick();
            vecs++;
            if (cfg_done !== 1'b0 || cfg_error !== err || done_cnt - c0 != 1) begin
                errs++;
                $display("FAIL done_single got done %b err %b count %0d want 0 %b 1",
                         cfg_done, cfg_error, done_cnt - c0, err);
            end
            bus_rd(3'd0, d, ack);
            vecs++;
            if (d !== m_status()) begin
                errs++;
                $display("FAIL idle_status got %h want %h", d, m_status());
            end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        logic ack;
        int n, c0;
        post_cmd(8'($urandom), $urandom, $urandom);
        c0 = done_cnt;
        n = 0;
        while (cfg_done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        vecs++;
        if (n != TO) begin
            errs++;
            $display("FAIL timeout_latency got %0d cycles want %0d", n, TO);
        end
        vecs++;
        if (cfg_error !== 1'b1 || cpu_irq !== 1'b0) begin
            errs++;
            $display("FAIL timeout_flags got err %b irq %b want 1 0", cfg_error, cpu_irq);
        end
        m_busy = 0; m_irq = 0; m_tflag = 1;
        tick();
        bus_rd(3'd0, d, ack);
        vecs++;
        if (d !== m_status() || done_cnt - c0 != 1) begin
            errs++;
            $display("FAIL timeout_status got %h count %0d want %h 1", d, done_cnt - c0, m_status());
        end
    endtask

    task automatic test_race();
        logic [31:0] d;
        logic ack;
        int c0;
        for (int e = 0; e < 2; e++) begin
            post_cmd(8'($urandom), $urandom, $urandom);
            repeat (TO - 1) tick();
            c0 = done_cnt;
            bus_wr(3'd6, {30'd0, 1'(e), 1'b1});
            m_busy = 1'b0;
            vecs++;
            if (cfg_done !== 1'b1 || cfg_error !== 1'(e)) begin
                errs++;
                $display("FAIL race_done got done %b err %b want 1 %0d", cfg_done, cfg_error, e);
            end
            repeat (3) tick();
            bus_rd(3'd0, d, ack);
            vecs++;
            if (d !== m_status() || done_cnt - c0 != 1) begin
                errs++;
                $display("FAIL race_status got %h count %0d want %h 1", d, done_cnt - c0, m_status());
            end
        end
    endtask

    task automatic test_n64_reset();
        logic [31:0] d, w;
        logic ack;
        int c0;
        post_cmd(8'($urandom), $urandom, $urandom);
        w = $urandom;
        bus_wr(3'd3, w); m_d0 = w;
        repeat (3) tick();
        c0 = done_cnt;
        n64_reset = 1'b1;
        tick();
        n64_reset = 1'b0;
        m_busy = 0; m_irq = 0; m_tflag = 0;
        vecs++;
        if (cpu_irq !== 1'b0 || cfg_done !== 1'b0 || cfg_wdata0 !== m_d0) begin
            errs++;
            $display("FAIL n64_reset_outputs got irq %b done %b wdata0 %h want 0 0 %h",
                     cpu_irq, cfg_done, cfg_wdata0, m_d0);
        end
        repeat (TO + 8) tick();
        bus_rd(3'd0, d, ack);
        vecs++;
        if (d[31:29] !== 3'b000 || done_cnt != c0) begin
            errs++;
            $display("FAIL n64_reset_abort got status %h count %0d want flags 000 count 0",
                     d, done_cnt - c0);
        end
        bus_rd(3'd3, d, ack);
        vecs++;
        if (d !== m_d0) begin
            errs++;
            $display("FAIL n64_reset_data0 got %h want %h", d, m_d0);
        end
    endtask

    task automatic test_irq_and_idle();
        logic [31:0] d;
        logic ack;
        int c0, i0;
        c0 = done_cnt; i0 = irq_cnt;
        bus_wr(3'd6, 32'h4);
        vecs++;
        if (cfg_irq !== 1'b1 || cfg_done !== 1'b0) begin
            errs++;
            $display("FAIL idle_irq got irq %b done %b want 1 0", cfg_irq, cfg_done);
        end
        tick();
        bus_wr(3'd6, 32'h3);
        tick();
        vecs++;
        if (irq_cnt - i0 != 1 || done_cnt != c0) begin
            errs++;
            $display("FAIL idle_done_ignored got irqs %0d dones %0d want 1 0", irq_cnt - i0, done_cnt - c0);
        end
        bus_wr(3'd1, $urandom);
        bus_rd(3'd1, d, ack);
        vecs++;
        if (d !== m_arg0) begin
            errs++;
            $display("FAIL ro_write_ignored got %h want %h", d, m_arg0);
        end
        bus_rd(3'd6, d, ack);
        vecs++;
        if (d !== 32'd0) begin
            errs++;
            $display("FAIL control_read got %h want 0", d);
        end
        bus_rd(3'd7, d, ack);
        vecs++;
        if (d !== 32'd0) begin
            errs++;
            $display("FAIL reserved_read got %h want 0", d);
        end
        post_cmd(8'($urandom), $urandom, $urandom);
        i0 = irq_cnt;
        bus_wr(3'd6, 32'h5);
        m_busy = 1'b0;
        vecs++;
        if (cfg_irq !== 1'b1 || cfg_done !== 1'b1 || cfg_error !== 1'b0) begin
            errs++;
            $display("FAIL busy_irq_done got irq %b done %b err %b want 1 1 0", cfg_irq, cfg_done, cfg_error);
        end
        repeat (2) tick();
        vecs++;
        if (irq_cnt - i0 != 1) begin
            errs++;
            $display("FAIL busy_irq_single got %0d want 1", irq_cnt - i0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, a2;
        logic [7:0] c2;
        logic ack;
        cfg_cmd = 8'($urandom); cfg_rdata0 = $urandom; cfg_rdata1 = $urandom;
        cfg_pending = 1'b1;
        tick();
        m_busy = 1; m_irq = 1; m_tflag = 0;
        m_cmd = cfg_cmd; m_arg0 = cfg_rdata0; m_arg1 = cfg_rdata1;
        c2 = 8'($urandom); a2 = $urandom;
        cfg_cmd = c2; cfg_rdata0 = a2;
        bus_wr(3'd6, 32'h1);
        m_busy = 1'b0;
        vecs++;
        if (cfg_done !== 1'b1) begin
            errs++;
            $display("FAIL b2b_done got %b want 1", cfg_done);
        end
        tick();
        bus_rd(3'd0, d, ack);
        vecs++;
        if (d !== m_status()) begin
            errs++;
            $display("FAIL b2b_idle_status got %h want %h", d, m_status());
        end
        m_busy = 1; m_irq = 1; m_cmd = c2; m_arg0 = a2; m_arg1 = cfg_rdata1;
        cfg_pending = 1'b0;
        bus_rd(3'd0, d, ack);
        vecs++;
        if (d !== m_status()) begin
            errs++;
            $display("FAIL b2b_recapture got %h want %h", d, m_status());
        end
        bus_rd(3'd1, d, ack);
        vecs++;
        if (d !== m_arg0) begin
            errs++;
            $display("FAIL b2b_arg0 got %h want %h", d, m_arg0);
        end
        bus_wr(3'd6, 32'h1);
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_race();
        test_n64_reset();
        test_irq_and_idle();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
